can_tx_scheduler: RTL and testbench
===================================

Name: can_tx_scheduler

Overview:
- Transmit-side controller for the CAN node: holds NUM_MB transmit mailboxes loaded by local requesters.
- Picks the pending mailbox with the highest CAN priority (lowest 11-bit ID) and hands its frame to the bit-level CAN transmit engine through a req/ack handshake.
- Tracks the outcome (done, lost arbitration, error), then retries, completes or fails the mailbox.
- Sits between system-side producers and the CAN node, in the sys_clk domain.

Parameters:
- NUM_MB, 4: number of mailboxes (2..8); IDX_W = $clog2(NUM_MB) is derived.
- MAX_ERR, 4'd8: tx_err count at which a mailbox is failed (1..15).
- BACKOFF_CYCLES, 16'd11: idle cycles in BACKOFF after lost/err before reselection (≥1).

Ports:
- sys_clk  in  1  clock; everything on posedge.
- reset  in  1  synchronous, active-high reset.
- mb_load  in  NUM_MB  one-hot load strobe, one bit per mailbox.
- mb_id  in  11  shared write bus, frame ID.
- mb_dlc  in  4  shared write bus, data length (values >8 clamp to 8).
- mb_data  in  64  shared write bus, data bytes (byte0 = [63:56]).
- mb_abort  in  NUM_MB  per-mailbox abort strobe.
- mb_pending  out  NUM_MB  mailbox holds an untransmitted frame.
- mb_done  out  NUM_MB  1-cycle pulse, frame sent.
- mb_error  out  NUM_MB  1-cycle pulse, frame failed after MAX_ERR errors.
- bus_idle  in  1  bus free (EOF + intermission seen).
- tx_req  out  1  frame valid for the engine.
- tx_ack  in  1  engine accepted the frame.
- tx_id  out  11  selected frame ID.
- tx_dlc  out  4  selected frame DLC.
- tx_data  out  64  selected frame data.
- tx_done  in  1  pulse, frame sent and ACKed.
- tx_lost  in  1  pulse, lost arbitration during the ID field.
- tx_err  in  1  pulse, bit/ACK/form error.
- active_mb  out  IDX_W  index of the mailbox in flight (valid while tx_req or busy).
- busy  out  1  state is REQUEST or ACTIVE.

Behaviour:
- Reset: all outputs 0; mb_pending = 0; per-mailbox error counters = 0; state IDLE. Mailbox contents are undefined and never read while not pending.
- Load:
  - mb_load[k] with !mb_pending[k] stores id/dlc/data and clears err_cnt[k].
  - mb_pending[k] is 1 on the next cycle.
  - A load to a pending mailbox is ignored.
  - Multiple load bits in one cycle all store the same bus values.
- Abort of an idle-pending mailbox: clears mb_pending[k] next cycle, with no done/error pulse. Abort wins over a same-cycle load.
- State machine, one transition per cycle:
  - IDLE: if |mb_pending && bus_idle, go to SELECT.
  - SELECT:
    - Choose the pending mailbox with the lowest mb_id; ties go to the lowest index.
    - Latch tx_id/tx_dlc/tx_data/active_mb.
    - Go to REQUEST. If no mailbox is still pending (aborted this cycle), go to IDLE.
  - REQUEST:
    - tx_req = 1, with tx_* held stable until tx_ack.
    - On tx_ack, tx_req drops next cycle and the state goes to ACTIVE.
    - Abort of active_mb before ack: tx_req drops, pending clears, go to IDLE.
  - ACTIVE: wait for an engine outcome. Same-cycle priority is done > err > lost.
    - tx_done: clear pending, pulse mb_done, go to IDLE.
    - tx_err: increment err_cnt (saturating). If it reaches MAX_ERR, clear pending, pulse mb_error, go to IDLE; otherwise go to BACKOFF.
    - tx_lost: err_cnt unchanged, go to BACKOFF. Lost arbitration retries without limit.
    - Abort of active_mb is latched and does not stop the frame. tx_done still reports done; tx_lost/tx_err then clear pending with no pulse and go to IDLE.
  - BACKOFF: count BACKOFF_CYCLES, then go to IDLE. Reselection re-evaluates priority, so a higher-priority load can preempt the retry.
- Latency: load at edge E0 gives pending after E0, SELECT at E1, tx_req high after E2 (bus_idle=1).
- tx_done/lost/err outside ACTIVE are ignored. tx_ack outside REQUEST is ignored.
- reset mid-frame: everything returns to reset values next cycle; no pulses are emitted.
- mb_done/mb_error are never asserted together and never for a non-active mailbox.

Test Plan:
- Load mb1 id 0x456, dlc 1, data 0x89…; bus_idle=1 → tx_req after 2 cycles with tx_id=0x456; ack then tx_done → mb_done[1] one cycle, mb_pending=0.
- Load mb0 id 0x456 and mb2 id 0x123 in the same cycle → tx_id=0x123, active_mb=2 first; then 0x456 after done.
- Equal IDs 0x200 in mb1 and mb3 → mb1 is served first.
- ACTIVE with tx_lost; load mb3 id 0x010 during BACKOFF → after 11 cycles tx_id=0x010 preempts; the original mailbox is sent afterwards.
- 8 consecutive tx_err on mb0 (MAX_ERR=8) → mb_error[0] pulse after the 8th, pending cleared, no mb_done.
- Abort active mb in REQUEST → tx_req drops, no pulses. Abort in ACTIVE then tx_done → mb_done still pulses. Assert reset during ACTIVE → all outputs 0 next cycle.

Source files
------------

// File: rtl/can_tx_scheduler.sv
// CAN transmit mailbox scheduler: NUM_MB mailboxes, lowest-ID arbitration,
// req/ack handoff to the bit engine, outcome tracking with retry/backoff.
module can_tx_scheduler #(
  parameter int unsigned NUM_MB         = 4,
  parameter logic [3:0]  MAX_ERR        = 4'd8,
  parameter logic [15:0] BACKOFF_CYCLES = 16'd11,
  localparam int unsigned IDX_W         = $clog2(NUM_MB)
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [NUM_MB-1:0] mb_load,
  input  logic [10:0]       mb_id,
  input  logic [3:0]        mb_dlc,
  input  logic [63:0]       mb_data,
  input  logic [NUM_MB-1:0] mb_abort,
  output logic [NUM_MB-1:0] mb_pending,
  output logic [NUM_MB-1:0] mb_done,
  output logic [NUM_MB-1:0] mb_error,
  input  logic              bus_idle,
  output logic              tx_req,
  input  logic              tx_ack,
  output logic [10:0]       tx_id,
  output logic [3:0]        tx_dlc,
  output logic [63:0]       tx_data,
  input  logic              tx_done,
  input  logic              tx_lost,
  input  logic              tx_err,
  output logic [IDX_W-1:0]  active_mb,
  output logic              busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_REQUEST,
    ST_ACTIVE,
    ST_BACKOFF
  } state_e;

  state_e state_q, state_d;

  logic [10:0] id_q   [NUM_MB];
  logic [10:0] id_d   [NUM_MB];
  logic [3:0]  dlc_q  [NUM_MB];
  logic [3:0]  dlc_d  [NUM_MB];
  logic [63:0] data_q [NUM_MB];
  logic [63:0] data_d [NUM_MB];
  logic [3:0]  err_q  [NUM_MB];
  logic [3:0]  err_d  [NUM_MB];

  logic [NUM_MB-1:0] pending_q, pending_d;
  logic [NUM_MB-1:0] done_q, done_d;
  logic [NUM_MB-1:0] error_q, error_d;
  logic [10:0]       tx_id_q, tx_id_d;
  logic [3:0]        tx_dlc_q, tx_dlc_d;
  logic [63:0]       tx_data_q, tx_data_d;
  logic [IDX_W-1:0]  active_q, active_d;
  logic              abort_lat_q, abort_lat_d;
  logic [15:0]       bo_cnt_q, bo_cnt_d;

  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [10:0]       sel_id;
  logic              in_flight;
  logic              abort_now;
  logic              abort_any;
  logic [3:0]        err_inc;

  // Priority pick: lowest ID among mailboxes still pending and not being aborted; strict < keeps lowest index on ties
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_id    = '1;
    for (int unsigned k = 0; k < NUM_MB; k++) begin
      if (pending_q[k] && !mb_abort[k] && (!sel_found || id_q[k] < sel_id)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(k);
        sel_id    = id_q[k];
      end
    end
  end

  // Mailbox load/abort handling plus the next-state and output logic of the scheduler FSM
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    dlc_d       = dlc_q;
    data_d      = data_q;
    err_d       = err_q;
    pending_d   = pending_q;
    done_d      = '0;
    error_d     = '0;
    tx_id_d     = tx_id_q;
    tx_dlc_d    = tx_dlc_q;
    tx_data_d   = tx_data_q;
    active_d    = active_q;
    abort_lat_d = abort_lat_q;
    bo_cnt_d    = bo_cnt_q;

    in_flight = (state_q == ST_REQUEST) || (state_q == ST_ACTIVE);
    abort_now = mb_abort[active_q];
    abort_any = abort_lat_q || abort_now;
    err_inc   = (err_q[active_q] == 4'hF) ? 4'hF : err_q[active_q] + 4'd1;

    // The in-flight mailbox is excluded here; its abort is resolved by the FSM below.
    for (int unsigned k = 0; k < NUM_MB; k++) begin
      if (mb_abort[k]) begin
        if (!(in_flight && active_q == IDX_W'(k))) begin
          pending_d[k] = 1'b0;
        end
      end else if (mb_load[k] && !pending_q[k]) begin
        id_d[k]      = mb_id;
        dlc_d[k]     = (mb_dlc > 4'd8) ? 4'd8 : mb_dlc;
        data_d[k]    = mb_data;
        err_d[k]     = '0;
        pending_d[k] = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (|pending_q && bus_idle) begin
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (sel_found) begin
          tx_id_d     = id_q[sel_idx];
          tx_dlc_d    = dlc_q[sel_idx];
          tx_data_d   = data_q[sel_idx];
          active_d    = sel_idx;
          abort_lat_d = 1'b0;
          state_d     = ST_REQUEST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQUEST: begin
        // Once the engine has accepted, the frame is committed; a same-cycle abort is only latched.
        if (tx_ack) begin
          abort_lat_d = abort_now;
          state_d     = ST_ACTIVE;
        end else if (abort_now) begin
          pending_d[active_q] = 1'b0;
          state_d             = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (abort_now) begin
          abort_lat_d = 1'b1;
        end
        if (tx_done) begin
          pending_d[active_q] = 1'b0;
          done_d[active_q]    = 1'b1;
          state_d             = ST_IDLE;
        end else if (tx_err) begin
          if (abort_any) begin
            pending_d[active_q] = 1'b0;
            state_d             = ST_IDLE;
          end else begin
            err_d[active_q] = err_inc;
            if (err_inc >= MAX_ERR) begin
              pending_d[active_q] = 1'b0;
              error_d[active_q]   = 1'b1;
              state_d             = ST_IDLE;
            end else begin
              bo_cnt_d = '0;
              state_d  = ST_BACKOFF;
            end
          end
        end else if (tx_lost) begin
          if (abort_any) begin
            pending_d[active_q] = 1'b0;
            state_d             = ST_IDLE;
          end else begin
            bo_cnt_d = '0;
            state_d  = ST_BACKOFF;
          end
        end
      end
      ST_BACKOFF: begin
        if (bo_cnt_q == BACKOFF_CYCLES - 16'd1) begin
          state_d = ST_IDLE;
        end else begin
          bo_cnt_d = bo_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state, counters and registered outputs with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      err_q       <= '{default: '0};
      pending_q   <= '0;
      done_q      <= '0;
      error_q     <= '0;
      tx_id_q     <= '0;
      tx_dlc_q    <= '0;
      tx_data_q   <= '0;
      active_q    <= '0;
      abort_lat_q <= 1'b0;
      bo_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      pending_q   <= pending_d;
      done_q      <= done_d;
      error_q     <= error_d;
      tx_id_q     <= tx_id_d;
      tx_dlc_q    <= tx_dlc_d;
      tx_data_q   <= tx_data_d;
      active_q    <= active_d;
      abort_lat_q <= abort_lat_d;
      bo_cnt_q    <= bo_cnt_d;
    end
  end

  // Mailbox frame storage; only meaningful while the mailbox is pending
  always_ff @(posedge sys_clk) begin
    id_q   <= id_d;
    dlc_q  <= dlc_d;
    data_q <= data_d;
  end

  assign mb_pending = pending_q;
  assign mb_done    = done_q;
  assign mb_error   = error_q;
  assign tx_req     = (state_q == ST_REQUEST);
  assign busy       = (state_q == ST_REQUEST) || (state_q == ST_ACTIVE);
  assign tx_id      = tx_id_q;
  assign tx_dlc     = tx_dlc_q;
  assign tx_data    = tx_data_q;
  assign active_mb  = active_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Bench for can_tx_scheduler: directed scenarios then randomized traffic
// checked against a mailbox-level reference model.
module tb_can_tx_scheduler;

  localparam int unsigned NMB     = 4;
  localparam int unsigned MAXE    = 8;
  localparam int unsigned BACKOFF = 11;

  logic           sys_clk = 1'b0;
  logic           reset;
  logic [NMB-1:0] mb_load;
  logic [10:0]    mb_id;
  logic [3:0]     mb_dlc;
  logic [63:0]    mb_data;
  logic [NMB-1:0] mb_abort;
  logic [NMB-1:0] mb_pending;
  logic [NMB-1:0] mb_done;
  logic [NMB-1:0] mb_error;
  logic           bus_idle;
  logic           tx_req;
  logic           tx_ack;
  logic [10:0]    tx_id;
  logic [3:0]     tx_dlc;
  logic [63:0]    tx_data;
  logic           tx_done;
  logic           tx_lost;
  logic           tx_err;
  logic [1:0]     active_mb;
  logic           busy;

  can_tx_scheduler #(
    .NUM_MB(NMB),
    .MAX_ERR(4'd8),
    .BACKOFF_CYCLES(16'd11)
  ) dut (
    .sys_clk(sys_clk), .reset(reset),
    .mb_load(mb_load), .mb_id(mb_id), .mb_dlc(mb_dlc), .mb_data(mb_data),
    .mb_abort(mb_abort), .mb_pending(mb_pending), .mb_done(mb_done), .mb_error(mb_error),
    .bus_idle(bus_idle), .tx_req(tx_req), .tx_ack(tx_ack),
    .tx_id(tx_id), .tx_dlc(tx_dlc), .tx_data(tx_data),
    .tx_done(tx_done), .tx_lost(tx_lost), .tx_err(tx_err),
    .active_mb(active_mb), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: mailbox contents, pending flags and error counts
  logic [10:0] m_id   [NMB];
  logic [3:0]  m_dlc  [NMB];
  logic [63:0] m_data [NMB];
  bit          m_pend [NMB];
  int          m_err  [NMB];
  int          cur_idx;
  int          checks   = 0;
  int          failures = 0;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NMB-1:0] mvec();
    logic [NMB-1:0] v = '0;
    for (int i = 0; i < NMB; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic int model_pick();
    int best = -1;
    for (int i = 0; i < NMB; i++)
      if (m_pend[i] && (best < 0 || m_id[i] < m_id[best])) best = i;
    return best;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NMB; i++) begin
      m_pend[i] = 0;
      m_err[i]  = 0;
    end
  endtask

  task automatic load_mb(input logic [NMB-1:0] mask, input logic [10:0] id,
                         input logic [3:0] dlc, input logic [63:0] data);
    mb_load = mask; mb_id = id; mb_dlc = dlc; mb_data = data;
    for (int i = 0; i < NMB; i++) begin
      if (mask[i] && !m_pend[i]) begin
        m_id[i]   = id;
        m_dlc[i]  = (dlc > 4'd8) ? 4'd8 : dlc;
        m_data[i] = data;
        m_pend[i] = 1;
        m_err[i]  = 0;
      end
    end
    tick();
    mb_load = '0;
    check("pending_after_load", mb_pending, mvec());
  endtask

  task automatic wait_req();
    for (int i = 0; i < 60 && !tx_req; i++) tick();
    if (!tx_req) check("tx_req_timeout", tx_req, 1'b1);
  endtask

  // Engine side: wait for a request, check the frame against the model choice, accept it
  task automatic accept();
    int stall;
    wait_req();
    cur_idx = model_pick();
    if (cur_idx < 0) begin
      check("req_without_pending", tx_req, 1'b0);
      cur_idx = 0;
    end
    check("tx_id", tx_id, m_id[cur_idx]);
    check("tx_dlc", tx_dlc, m_dlc[cur_idx]);
    check("tx_data", tx_data, m_data[cur_idx]);
    check("active_mb", active_mb, cur_idx);
    check("busy_req", busy, 1'b1);
    stall = $urandom_range(0, 2);
    for (int i = 0; i < stall; i++) tick();
    check("tx_req_held", {tx_req, tx_id}, {1'b1, m_id[cur_idx]});
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    check("req_drop_after_ack", {tx_req, busy}, 2'b01);
  endtask

  // kind: 0 done, 1 err, 2 lost
  task automatic outcome(input int kind, input bit aborted);
    logic [NMB-1:0] exp_done = '0;
    logic [NMB-1:0] exp_err  = '0;
    int k = cur_idx;
    tx_done = (kind == 0); tx_err = (kind == 1); tx_lost = (kind == 2);
    tick();
    tx_done = 1'b0; tx_err = 1'b0; tx_lost = 1'b0;
    if (kind == 0) begin
      m_pend[k] = 0;
      exp_done[k] = 1'b1;
    end else if (aborted) begin
      m_pend[k] = 0;
    end else if (kind == 1) begin
      m_err[k]++;
      if (m_err[k] >= MAXE) begin
        m_pend[k] = 0;
        exp_err[k] = 1'b1;
      end
    end
    check("mb_done_pulse", mb_done, exp_done);
    check("mb_error_pulse", mb_error, exp_err);
    check("pending_after_outcome", mb_pending, mvec());
    check("busy_after_outcome", busy, 1'b0);
    tick();
    check("pulses_one_cycle", {mb_done, mb_error}, '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; mb_load = '0; mb_id = '0; mb_dlc = '0; mb_data = '0; mb_abort = '0;
    bus_idle = 1'b0; tx_ack = 1'b0; tx_done = 1'b0; tx_lost = 1'b0; tx_err = 1'b0;
    model_reset();
    repeat (3) tick();
    check("reset_outputs", {tx_req, busy, mb_pending, mb_done, mb_error, active_mb}, '0);
    check("reset_frame", {tx_id, tx_dlc}, '0);
    check("reset_data", tx_data, '0);
    reset = 1'b0;

    // Single frame and request latency
    bus_idle = 1'b1;
    load_mb(4'b0010, 11'h456, 4'd1, 64'h89AB_CDEF_0123_4567);
    check("latency_e1", tx_req, 1'b0);
    tick();
    check("latency_e1b", tx_req, 1'b0);
    tick();
    check("latency_e2", tx_req, 1'b1);
    accept();
    outcome(0, 0);

    // Priority by ID, then tie-break on index with a multi-bit load
    bus_idle = 1'b0;
    load_mb(4'b0001, 11'h456, 4'd12, 64'h1111_2222_3333_4444);
    load_mb(4'b0100, 11'h123, 4'd3, 64'h5555_6666_7777_8888);
    bus_idle = 1'b1;
    accept(); check("prio_first", active_mb, 2'd2); outcome(0, 0);
    accept(); outcome(0, 0);
    bus_idle = 1'b0;
    load_mb(4'b1010, 11'h200, 4'd8, 64'hDEAD_BEEF_0000_0001);
    bus_idle = 1'b1;
    accept(); check("tie_first", active_mb, 2'd1); outcome(0, 0);
    accept(); outcome(0, 0);

    // Lost arbitration, preemption during backoff, backoff length
    load_mb(4'b0001, 11'h300, 4'd2, 64'hA5A5_A5A5_0000_0000);
    accept();
    outcome(2, 0);
    n = 1;
    load_mb(4'b1000, 11'h010, 4'd4, 64'h0102_0304_0506_0708);
    n++;
    while (!tx_req && n < 60) begin tick(); n++; end
    check("backoff_latency", n, BACKOFF + 2);
    accept(); check("preempt", active_mb, 2'd3); outcome(0, 0);
    accept(); check("retry_after_preempt", active_mb, 2'd0); outcome(0, 0);

    // Error limit
    load_mb(4'b0001, 11'h111, 4'd5, 64'h0F0F_0F0F_F0F0_F0F0);
    for (int i = 0; i < MAXE; i++) begin
      accept();
      outcome(1, 0);
    end
    check("err_limit_pending", mb_pending, '0);

    // Abort while requesting
    load_mb(4'b0100, 11'h222, 4'd0, 64'h0);
    wait_req();
    mb_abort = 4'b0100; m_pend[2] = 0;
    tick();
    mb_abort = '0;
    check("abort_req_drop", {tx_req, busy, mb_pending, mb_done, mb_error}, '0);
    repeat (3) tick();
    check("abort_req_stays_idle", tx_req, 1'b0);

    // Abort while active: done still reported; lost clears silently
    load_mb(4'b0010, 11'h333, 4'd6, 64'hCAFE_F00D_1234_5678);
    accept();
    mb_abort = 4'b0010;
    tick();
    mb_abort = '0;
    check("abort_active_pending", mb_pending, 4'b0010);
    outcome(0, 1);
    load_mb(4'b0010, 11'h334, 4'd6, 64'h1);
    accept();
    mb_abort = 4'b0010;
    tick();
    mb_abort = '0;
    outcome(2, 1);

    // Abort of idle-pending mailbox; abort beats same-cycle load
    bus_idle = 1'b0;
    load_mb(4'b1000, 11'h044, 4'd1, 64'h2);
    mb_abort = 4'b1000; m_pend[3] = 0;
    tick();
    mb_abort = '0;
    check("abort_idle", mb_pending, mvec());
    mb_load = 4'b0100; mb_abort = 4'b0100;
    tick();
    mb_load = '0; mb_abort = '0;
    check("abort_wins_load", mb_pending, mvec());

    // Reset mid-frame
    bus_idle = 1'b1;
    load_mb(4'b0001, 11'h055, 4'd7, 64'h3);
    accept();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check("reset_mid_frame", {tx_req, busy, mb_pending, mb_done, mb_error, active_mb, tx_id}, '0);

    // Randomized traffic
    for (int r = 0; r < 20; r++) begin
      bus_idle = 1'b0;
      for (int l = 0; l < int'($urandom_range(1, 3)); l++) begin
        load_mb(4'($urandom_range(1, 15)),
                ($urandom_range(0, 2) == 0) ? 11'(11'h100 + $urandom_range(0, 3)) : 11'($urandom),
                4'($urandom), {$urandom, $urandom});
      end
      bus_idle = 1'b1;
      for (int f = 0; f < 100 && model_pick() >= 0; f++) begin
        int p = $urandom_range(0, 9);
        accept();
        outcome((p < 5) ? 0 : ((p < 8) ? 1 : 2), 0);
      end
      check("random_drained", mb_pending, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
